fb_scanout: RTL and testbench
=============================

// Module: fb_scanout
// PURPOSE
//  Scanout stage downstream of the 640x480x12 dual-port framebuffer RAM. Generates 640x480@60 VGA timing.
//  Drives the RAM read port (rdaddress, 1-cycle sync read) and aligns the returned pixel with sync/DE.
//  Outputs RGB444 plus HS/VS. Supports double buffering: new frame base address latched only at frame boundary.
// PARAMETERS
//  WIDTH     12   pixel width; RGB444, R=[11:8] G=[7:4] B=[3:0]
//  ADDRW     19   framebuffer address width
//  H_ACTIVE  640  visible pixels/line;  H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
//  V_ACTIVE  480  visible lines/frame;  V_FP 10, V_SYNC 2,  V_BP 33 (frame total 525)
//  RD_LAT    1    RAM read latency in clocks; sync/DE delay matches this
//  SYNC_POL  0    active level of vga_hs/vga_vs (0 = active-low)
// PORTS
//  clock       in   1      pixel clock (25.175 MHz nominal); same clock as RAM rdclock
//  reset_n     in   1      synchronous, active-low reset
//  rdaddress   out  ADDRW  framebuffer read address
//  q           in   WIDTH  framebuffer read data, valid RD_LAT clocks after rdaddress
//  flip_req    in   1      level; request to display buffer at flip_base from next frame
//  flip_base   in   ADDRW  base address of new buffer, stable while flip_req high
//  flip_ack    out  1      1-cycle pulse: flip_base taken, active from next frame
//  frame_start out  1      1-cycle pulse at h=0,v=0 of pipeline stage 0
//  vga_r/g/b   out  4 each pixel colour, zero outside active video
//  vga_hs      out  1      horizontal sync
//  vga_vs      out  1      vertical sync
//  vga_de      out  1      display enable, aligned with vga_r/g/b
// BEHAVIOUR
//  - Stage 0 (S0): hcnt 0..799, vcnt 0..524. hcnt wraps at 799 and increments vcnt; vcnt wraps at 524.
//  - Active video when hcnt<640 && vcnt<480.
//  - HS asserted for hcnt 656..751; VS asserted for vcnt 490..491 (whole lines).
//  - Address is incremental; no multiplier.
//    - rdaddress = base + pix_idx, pix_idx advancing by 1 per active pixel; sum wraps mod 2^ADDRW.
//    - rdaddress is registered from S0, so RAM data arrives at stage RD_LAT+1.
//    - During blanking rdaddress holds its last value.
//    - At (hcnt=799,vcnt=524) pix_idx resets to 0.
//  - de/hs/vs are delayed RD_LAT+1 clocks from S0 so they align with q.
//    - Output stage registers rgb = de ? q : 0.
//    - Total latency from S0 counter to pins is RD_LAT+2 clocks.
//  - Page flip:
//    - base register is updated only at cycle hcnt=799,vcnt=524.
//    - If flip_req=1 on that cycle: base<=flip_base, flip_ack=1 for that one clock.
//    - Requester must drop flip_req after ack.
//    - flip_req asserted later in that same cycle's frame waits for the next boundary; no mid-frame tearing.
//  - Reset (reset_n=0 at posedge) applies to all state, including mid-frame:
//    - hcnt=vcnt=0, pix_idx=0, base=0, pipeline flushed.
//    - de=0, rgb=0, hs=vs=!SYNC_POL (inactive), flip_ack=0, frame_start=0, rdaddress=0.
//    - First post-reset cycle is h=0,v=0 with frame_start=1.
//    - A flip_req pending across reset is not acked until the next frame boundary.
//  - Buffer overrun: base+307199 >= DEPTH is a caller error; the block wraps and does not flag it.
// STRUCTURE
//  - Package fb_pkg:
//    - Timing constants H_*/V_* and derived H_TOTAL=800, V_TOTAL=525, FB_PIXELS=307200.
//    - typedef rgb444_t (packed struct r,g,b of 4 bits each).
//    - typedef fb_addr_t (logic [ADDRW-1:0]).
//  - Sub-module vga_timing: counters plus raw hs/vs/de/frame_start/frame_end.
//  - fb_scanout holds address generation, base/flip logic, and alignment pipeline.
// TESTING (bench instantiates ram_2p preloaded so memory[a]=a[11:0])
//  1. Reset, run 1 frame:
//     -> 800*525=420000 clocks between frame_start pulses.
//     -> vga_hs low for 96 clocks per line.
//     -> vga_vs low for exactly 1600 clocks.
//  2. First active line after reset:
//     -> vga_de rises RD_LAT+2 clocks after frame_start.
//     -> rgb sequence is 0x000,0x001,...,0x27F.
//     -> rgb=0 while de=0.
//  3. Line 1, pixel 0 -> rgb=0x280 (addr 640). Last pixel of frame -> addr 307199, rgb=0xFFF.
//  4. flip_req=1, flip_base=307200 mid-frame:
//     -> no ack until h=799,v=524, then flip_ack pulse.
//     -> next frame's first rdaddress = 307200.
//  5. flip_base=0x7FFFF:
//     -> second pixel address wraps to 0x00000.
//  6. reset_n low for 1 clock at h=300,v=200:
//     -> outputs return to reset values next clock.
//     -> frame restarts at h=0,v=0.
//     -> base=0; pending flip is acked only at the next boundary.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared timing defaults and pixel/sync types for the framebuffer scanout path.
// Defaults describe 640x480@60 VGA with an RGB444 framebuffer.
package fb_pkg;

  localparam int FB_WIDTH = 12;
  localparam int FB_ADDRW = 19;

  localparam int H_ACTIVE_DFLT = 640;
  localparam int H_FP_DFLT     = 16;
  localparam int H_SYNC_DFLT   = 96;
  localparam int H_BP_DFLT     = 48;
  localparam int V_ACTIVE_DFLT = 480;
  localparam int V_FP_DFLT     = 10;
  localparam int V_SYNC_DFLT   = 2;
  localparam int V_BP_DFLT     = 33;

  localparam int H_TOTAL   = H_ACTIVE_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;
  localparam int V_TOTAL   = V_ACTIVE_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;
  localparam int FB_PIXELS = H_ACTIVE_DFLT * V_ACTIVE_DFLT;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic [FB_ADDRW-1:0] fb_addr_t;

  // Sync/DE flags travel as "asserted" booleans; polarity is applied at the pins.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read port plus the double-buffer flip handshake.
// master = scanout side, slave = RAM / frame producer side.
interface fb_scanout_if #(
  parameter int WIDTH = fb_pkg::FB_WIDTH,
  parameter int ADDRW = fb_pkg::FB_ADDRW
);
  logic [ADDRW-1:0] rdaddress;
  logic [WIDTH-1:0] q;
  logic             flip_req;
  logic [ADDRW-1:0] flip_base;
  logic             flip_ack;

  modport master (output rdaddress, flip_ack, input q, flip_req, flip_base);
  modport slave  (input rdaddress, flip_ack, output q, flip_req, flip_base);
endinterface

// File: rtl/fb_scanout_timing.sv
// Stage-0 raster counters for VGA timing: raw sync/DE flags and frame markers.
// frame_end marks the very last clock of a frame (last column of last line).
module vga_timing import fb_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int H_FP     = H_FP_DFLT,
  parameter int H_SYNC   = H_SYNC_DFLT,
  parameter int H_BP     = H_BP_DFLT,
  parameter int V_ACTIVE = V_ACTIVE_DFLT,
  parameter int V_FP     = V_FP_DFLT,
  parameter int V_SYNC   = V_SYNC_DFLT,
  parameter int V_BP     = V_BP_DFLT
) (
  input  logic  clock,
  input  logic  reset_n,
  output sync_t sync,
  output logic  frame_start,
  output logic  frame_end
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last;

  always_comb begin
    h_last = (hcnt_q == H_LAST);
    v_last = (vcnt_q == V_LAST);
    hcnt_d = h_last ? '0 : hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + VW'(1);

    sync.de     = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    sync.hs     = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    sync.vs     = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    frame_end   = h_last && v_last;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: incremental read addressing, frame-boundary page flip,
// and sync/DE delay so pins carry RAM data aligned with timing.
module fb_scanout import fb_pkg::*; #(
  parameter int WIDTH    = FB_WIDTH,
  parameter int ADDRW    = FB_ADDRW,
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int H_FP     = H_FP_DFLT,
  parameter int H_SYNC   = H_SYNC_DFLT,
  parameter int H_BP     = H_BP_DFLT,
  parameter int V_ACTIVE = V_ACTIVE_DFLT,
  parameter int V_FP     = V_FP_DFLT,
  parameter int V_SYNC   = V_SYNC_DFLT,
  parameter int V_BP     = V_BP_DFLT,
  parameter int RD_LAT   = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  fb_scanout_if.master       bus,
  output logic               frame_start,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de
);
  // Address register is one stage, RAM adds RD_LAT more.
  localparam int STAGES = RD_LAT + 1;

  sync_t s0;
  logic  fs_raw, frame_end;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock       (clock),
    .reset_n     (reset_n),
    .sync        (s0),
    .frame_start (fs_raw),
    .frame_end   (frame_end)
  );

  logic [ADDRW-1:0]   base_q, base_d;
  logic [ADDRW-1:0]   pix_idx_q, pix_idx_d;
  logic [ADDRW-1:0]   rdaddress_q, rdaddress_d;
  sync_t [STAGES:1]   sync_pipe_q, sync_pipe_d;
  rgb444_t            rgb_q, rgb_d;
  logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic               flip_take;
  logic [WIDTH-1:0]   pix;

  assign pix = bus.q;

  always_comb begin
    // The base only ever moves on the last clock of a frame, so a frame never tears.
    flip_take = frame_end & bus.flip_req;
    base_d    = flip_take ? bus.flip_base : base_q;

    pix_idx_d   = pix_idx_q;
    rdaddress_d = rdaddress_q;
    if (s0.de) begin
      rdaddress_d = base_q + pix_idx_q;
      pix_idx_d   = pix_idx_q + ADDRW'(1);
    end
    if (frame_end) pix_idx_d = '0;

    sync_pipe_d[1] = s0;
    for (int i = 2; i <= STAGES; i++) sync_pipe_d[i] = sync_pipe_q[i-1];

    de_d  = sync_pipe_q[STAGES].de;
    hs_d  = sync_pipe_q[STAGES].hs ? SYNC_POL : ~SYNC_POL;
    vs_d  = sync_pipe_q[STAGES].vs ? SYNC_POL : ~SYNC_POL;
    rgb_d = sync_pipe_q[STAGES].de ? rgb444_t'(pix) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      base_q      <= '0;
      pix_idx_q   <= '0;
      rdaddress_q <= '0;
      sync_pipe_q <= '0;
      de_q        <= 1'b0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      rgb_q       <= '0;
    end else begin
      base_q      <= base_d;
      pix_idx_q   <= pix_idx_d;
      rdaddress_q <= rdaddress_d;
      sync_pipe_q <= sync_pipe_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.rdaddress = rdaddress_q;
  assign bus.flip_ack  = flip_take;
  assign frame_start   = fs_raw & reset_n;
  assign vga_r         = rgb_q.r;
  assign vga_g         = rgb_q.g;
  assign vga_b         = rgb_q.b;
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_de        = de_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced raster (25x15 clocks, 16x8 visible) with a
// 1-cycle RAM model returning addr[11:0]; per-cycle scoreboard plus frame probes.
module tb_fb_scanout;
  localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VSY = 2, VB = 3;
  localparam int HT   = HA + HF + HSY + HB;
  localparam int VT   = VA + VF + VSY + VB;
  localparam int FT   = HT * VT;
  localparam int LAT  = 3;
  localparam int NPIX = HA * VA;

  typedef struct packed { logic de; logic hs; logic vs; logic [11:0] rgb; } out_t;
  typedef struct { out_t o; int pidx; } sb_t;
  typedef struct { bit flip; logic [18:0] fbase; logic [11:0] px0; logic [11:0] px1; logic [11:0] pxl; } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start, vga_hs, vga_vs, vga_de;
  logic [3:0] vga_r, vga_g, vga_b;

  int n_checks = 0;
  int n_fail   = 0;

  fb_scanout_if #(.WIDTH(12), .ADDRW(19)) bus ();

  fb_scanout #(
    .WIDTH(12), .ADDRW(19),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .RD_LAT(1), .SYNC_POL(1'b0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .frame_start (frame_start),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de)
  );

  always #5 clock = ~clock;

  // RAM preloaded so memory[a] = a[11:0]
  always @(posedge clock) bus.q <= bus.rdaddress[11:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference raster model and scoreboard
  sb_t         sbq[$];
  logic [11:0] cap [0:NPIX-1];
  bit          rst_seen = 1'b0;
  int          n = 0;
  logic [18:0] base_m = '0;
  logic [18:0] rdaddr_m = '0;

  always @(negedge clock) begin : mon
    int          p, h, v;
    bit          act, exp_fs, exp_ack;
    logic [18:0] addr;
    sb_t         e, got;
    if (rst_seen) begin
      p = n % FT;
      h = p % HT;
      v = p / HT;
      act = (h < HA) && (v < VA);
      addr = base_m + 19'(v * HA + h);
      e.o.de  = act;
      e.o.hs  = !((h >= HA + HF) && (h < HA + HF + HSY));
      e.o.vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
      e.o.rgb = act ? addr[11:0] : 12'h000;
      e.pidx  = act ? v * HA + h : -1;
      sbq.push_back(e);
      got = sbq.pop_front();
      chk("pixel_out", 32'({vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'(got.o));
      if (got.pidx >= 0) cap[got.pidx] = {vga_r, vga_g, vga_b};
      exp_fs  = (p == 0) && reset_n;
      exp_ack = (p == FT - 1) && bus.flip_req;
      chk("s0_ctl", 32'({frame_start, bus.flip_ack, bus.rdaddress}), 32'({exp_fs, exp_ack, rdaddr_m}));
      if (reset_n) begin
        if (act) rdaddr_m = addr;
        if (exp_ack) base_m = bus.flip_base;
        n++;
      end
    end
    if (!reset_n) begin
      rst_seen = 1'b1;
      n = 0;
      base_m = '0;
      rdaddr_m = '0;
      sbq.delete();
      e.o = {1'b0, 1'b1, 1'b1, 12'h000};
      e.pidx = -1;
      for (int i = 0; i < LAT; i++) sbq.push_back(e);
    end
  end

  task automatic wait_fs(input string name);
    int k = 0;
    while (!frame_start && k < FT + 10) begin
      @(negedge clock);
      k++;
    end
    chk({name, "_fs_seen"}, 32'(frame_start), 32'd1);
  endtask

  initial begin
    vec_t vt[5];
    int   cnt, hs_lo, vs_lo, de_hi, de_rise, k;

    vt[0] = '{1'b0, 19'h00000, 12'h000, 12'h001, 12'h07F};
    vt[1] = '{1'b1, 19'h00100, 12'h100, 12'h101, 12'h17F};
    vt[2] = '{1'b1, 19'h7FFFF, 12'hFFF, 12'h000, 12'h07E};
    vt[3] = '{1'b1, 19'h4B000, 12'h000, 12'h001, 12'h07F};
    vt[4] = '{1'b1, 19'h4B123, 12'h123, 12'h124, 12'h1A2};

    bus.flip_req  = 1'b0;
    bus.flip_base = '0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("fs_first_cycle", 32'(frame_start), 32'd1);
    chk("rst_outputs", 32'({vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'h3000);

    // One full frame: period, sync widths, DE count and first-DE latency
    cnt = 0; hs_lo = 0; vs_lo = 0; de_hi = 0; de_rise = -1;
    do begin
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (vga_de) de_hi++;
      if (vga_de && de_rise < 0) de_rise = cnt;
      cnt++;
      @(negedge clock);
    end while (!frame_start && cnt < FT + 50);
    chk("frame_period", 32'(cnt), 32'(FT));
    chk("hs_low_clocks", 32'(hs_lo), 32'(HSY * VT));
    chk("vs_low_clocks", 32'(vs_lo), 32'(VSY * HT));
    chk("de_clocks", 32'(de_hi), 32'(NPIX));
    chk("de_latency", 32'(de_rise), 32'(LAT));

    for (int r = 0; r < 5; r++) begin
      if (vt[r].flip) begin
        repeat (100) @(posedge clock);
        #1 bus.flip_base = vt[r].fbase;
        bus.flip_req = 1'b1;
        k = 0;
        @(negedge clock);
        while (!bus.flip_ack && k < FT + 10) begin
          @(negedge clock);
          k++;
        end
        chk("flip_ack_seen", 32'(bus.flip_ack), 32'd1);
        @(posedge clock);
        #1 bus.flip_req = 1'b0;
        @(negedge clock);
        chk("fs_after_ack", 32'(frame_start), 32'd1);
      end
      wait_fs("row");
      repeat (200) @(negedge clock);
      chk("row_px0", 32'(cap[0]), 32'(vt[r].px0));
      chk("row_px1", 32'(cap[1]), 32'(vt[r].px1));
      chk("row_pxlast", 32'(cap[NPIX-1]), 32'(vt[r].pxl));
    end

    // Single-clock reset at h=10,v=5 with a flip request already pending
    wait_fs("pre_reset");
    repeat (5 * HT + 10) @(posedge clock);
    #1 reset_n = 1'b0;
    bus.flip_req  = 1'b1;
    bus.flip_base = 19'h00200;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("midrst_outputs", 32'({vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'h3000);
    chk("midrst_rdaddr", 32'(bus.rdaddress), 32'd0);
    chk("midrst_fs", 32'(frame_start), 32'd1);
    chk("midrst_ack", 32'(bus.flip_ack), 32'd0);
    k = 0;
    while (!bus.flip_ack && k < FT + 10) begin
      @(negedge clock);
      k++;
    end
    chk("midrst_ack_delay", 32'(k), 32'(FT - 1));
    chk("midrst_frame_px0", 32'(cap[0]), 32'h000);
    chk("midrst_frame_pxlast", 32'(cap[NPIX-1]), 32'h07F);
    @(posedge clock);
    #1 bus.flip_req = 1'b0;
    wait_fs("post_reset");
    repeat (200) @(negedge clock);
    chk("flipped_px0", 32'(cap[0]), 32'h200);
    chk("flipped_pxlast", 32'(cap[NPIX-1]), 32'h27F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
